// File: rtl/axi_wr_pkg.sv
// Shared encodings for the AXI write-side slave memory bridge: burst types,
// controller states, captured AW attributes and the legal WRAP length set.
package axi_wr_pkg;

  localparam int unsigned LEN_W  = 8;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BURST = 2'b01,
    RESP  = 2'b10
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    burst_e            burst;
  } aw_attr_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [LEN_W-1:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_beat_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts.
module axi_beat_addr
  import axi_wr_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic [AW-1:0]     addr,
  input  logic [SIZE_W-1:0] size,
  input  logic [LEN_W-1:0]  len,
  input  burst_e            burst,
  output logic [AW-1:0]     next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] step_mask;
  logic [AW-1:0] wrap_bnd;
  logic [AW-1:0] wrap_mask;

  always_comb begin
    step      = AW'(1) << size;
    step_mask = step - AW'(1);
    wrap_bnd  = AW'({1'b0, len} + 9'd1) << size;
    wrap_mask = wrap_bnd - AW'(1);
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:     next_addr = (addr & ~step_mask) + step;
    endcase
  end

endmodule

// File: rtl/axi_slave_wmem.sv
// AXI write-channel slave that streams accepted W beats straight onto a
// memory write port, tracking burst addressing and flagging protocol errors.
module axi_slave_wmem
  import axi_wr_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 64,
  parameter int unsigned MAXSIZE = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [LEN_W-1:0]  s_axi_awlen,
  input  logic [SIZE_W-1:0] s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              aw_fire,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              write_ready,
  input  logic              b_fire,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic              mem_ready,
  output logic              burst_done,
  output logic              wr_err,
  output logic              busy
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAXSIZE);

  state_e            state_q, state_d;
  aw_attr_t          attr_q, attr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [AW-1:0]     next_addr;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              burst_done_q, burst_done_d;
  logic              wr_err_q, wr_err_d;
  logic              beat_acc;
  logic              last_beat;
  logic              aw_illegal;
  burst_e            aw_burst;

  // Classify the incoming AW; illegal requests degrade to a clamped INCR.
  always_comb begin
    aw_burst   = burst_e'(s_axi_awburst);
    aw_illegal = (aw_burst == BURST_RSVD) || (s_axi_awsize > MAX_SIZE) ||
                 ((aw_burst == BURST_WRAP) && !wrap_len_legal(s_axi_awlen));
  end

  assign write_ready = (state_q == BURST) & mem_ready;
  assign beat_acc    = s_axi_wvalid & write_ready;
  assign last_beat   = (cnt_q == attr_q.len);

  // Zero-latency memory port: the W beat is forwarded in its acceptance cycle.
  assign mem_we      = beat_acc;
  assign mem_addr    = addr_q;
  assign mem_wdata   = s_axi_wdata;
  assign mem_wstrb   = s_axi_wstrb;

  assign burst_done  = burst_done_q;
  assign wr_err      = wr_err_q;
  assign busy        = (state_q != IDLE);

  axi_beat_addr #(
    .AW(AW)
  ) u_beat_addr (
    .addr     (addr_q),
    .size     (attr_q.size),
    .len      (attr_q.len),
    .burst    (attr_q.burst),
    .next_addr(next_addr)
  );

  always_comb begin
    state_d      = state_q;
    attr_d       = attr_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    burst_done_d = 1'b0;
    wr_err_d     = wr_err_q;

    case (state_q)
      IDLE: begin
        if (b_fire) wr_err_d = 1'b1;
        if (aw_fire) begin
          state_d      = BURST;
          addr_d       = s_axi_awaddr;
          cnt_d        = '0;
          attr_d.len   = s_axi_awlen;
          attr_d.size  = (s_axi_awsize > MAX_SIZE) ? MAX_SIZE : s_axi_awsize;
          attr_d.burst = aw_illegal ? BURST_INCR : aw_burst;
          if (aw_illegal) wr_err_d = 1'b1;
        end
      end

      BURST: begin
        if (aw_fire || b_fire) wr_err_d = 1'b1;
        if (beat_acc) begin
          // The beat counter, not wlast, decides where the burst ends.
          if (s_axi_wlast != last_beat) wr_err_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          addr_d = next_addr;
          if (last_beat) begin
            state_d      = RESP;
            burst_done_d = 1'b1;
          end
        end
      end

      RESP: begin
        if (aw_fire) wr_err_d = 1'b1;
        if (b_fire) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      attr_q       <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      burst_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      attr_q       <= attr_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      burst_done_q <= burst_done_d;
      wr_err_q     <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_wmem.sv
// Scoreboard bench for axi_slave_wmem: expected memory writes are queued when
// a burst is issued and a negedge monitor checks every cycle of the port.
module tb_axi_slave_wmem;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        aw_fire;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        write_ready;
  logic        b_fire;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ready;
  logic        burst_done;
  logic        wr_err;
  logic        busy;

  axi_slave_wmem #(.AW(32), .DW(64), .MAXSIZE(3)) dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .aw_fire(aw_fire),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
    .write_ready(write_ready), .b_fire(b_fire),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .burst_done(burst_done), .wr_err(wr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    exp_in_burst = 1'b0;
  bit    exp_err = 1'b0;
  bit    last_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference beat address straight from the burst rules.
  function automatic logic [31:0] ref_addr(input logic [31:0] a0, input int len,
                                           input int size, input int burst, input int n);
    longint step, bnd, base, a;
    a    = longint'(a0);
    step = longint'(1) << size;
    if (burst == 0) return a0;
    if (burst == 1) begin
      if (n == 0) return a0;
      return 32'((a / step) * step + longint'(n) * step);
    end
    bnd  = longint'(len + 1) * step;
    base = (a / bnd) * bnd;
    return 32'(base + ((a + longint'(n) * step) % bnd));
  endfunction

  // Monitor: every cycle compare handshake outputs and pop on memory writes.
  always @(negedge clk) begin
    beat_t it;
    bit    exp_acc;
    if (!resetn) begin
      last_prev <= 1'b0;
    end else begin
      exp_acc = exp_in_burst && mem_ready && s_axi_wvalid;
      chk("write_ready", 64'(write_ready), 64'(exp_in_burst && mem_ready));
      chk("mem_we", 64'(mem_we), 64'(exp_acc));
      chk("burst_done", 64'(burst_done), 64'(last_prev));
      last_prev <= 1'b0;
      if (mem_we && exp_acc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(1), 64'(0));
        end else begin
          it = exp_q.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(it.addr));
          chk("mem_wdata", mem_wdata, it.data);
          chk("mem_wstrb", 64'(mem_wstrb), 64'(it.strb));
          last_prev <= it.last;
        end
      end
    end
  end

  task automatic idle_inputs();
    aw_fire = 1'b0; b_fire = 1'b0; s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    exp_in_burst = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    s_axi_wvalid = 1'b1; mem_ready = 1'b1;
    aw_fire = 1'b0; b_fire = 1'b0; exp_in_burst = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_write_ready", 64'(write_ready), 64'(0));
    exp_q.delete();
    exp_err = 1'b0;
    @(posedge clk); #1;
    chk("rst_wr_err", 64'(wr_err), 64'(0));
    chk("rst_burst_done", 64'(burst_done), 64'(0));
    resetn = 1'b1;
    idle_inputs();
  endtask

  // misuse: 1 = aw_fire in BURST, 2 = b_fire in BURST, 3 = aw_fire in RESP.
  task automatic do_burst(input logic [31:0] a0, input int len, input int size,
                          input int burst, input bit rnd, input logic [31:0] low_mask,
                          input int flip, input int misuse, input int rst_after,
                          input int resp_wait);
    logic [63:0] d[256];
    logic [7:0]  s[256];
    int          eff_burst, eff_size, n, k;
    bit          illegal;
    beat_t       it;
    illegal   = (burst == 3) || (size > 3) ||
                (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    eff_burst = illegal ? 1 : burst;
    eff_size  = (size > 3) ? 3 : size;
    for (int i = 0; i <= len; i++) begin
      d[i] = {$urandom, $urandom};
      s[i] = 8'($urandom);
      it.addr = ref_addr(a0, len, eff_size, eff_burst, i);
      it.data = d[i];
      it.strb = s[i];
      it.last = (i == len);
      exp_q.push_back(it);
    end
    if (illegal) exp_err = 1'b1;

    @(posedge clk); #1;
    idle_inputs();
    aw_fire = 1'b1; s_axi_awaddr = a0; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst);
    mem_ready = 1'($urandom_range(0, 1));

    n = 0; k = 0;
    while (n <= len) begin
      if (rst_after >= 0 && n == rst_after) begin
        apply_reset();
        return;
      end
      @(posedge clk); #1;
      aw_fire = 1'b0; b_fire = 1'b0;
      exp_in_burst = 1'b1;
      s_axi_wvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_ready    = low_mask[k % 32] ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (k > 60) begin s_axi_wvalid = 1'b1; mem_ready = 1'b1; end
      s_axi_wdata = d[n]; s_axi_wstrb = s[n];
      s_axi_wlast = (n == len) ^ (n == flip);
      if (k == 0 && misuse == 1) begin
        aw_fire = 1'b1; s_axi_awaddr = 32'($urandom); exp_err = 1'b1;
      end
      if (k == 0 && misuse == 2) begin b_fire = 1'b1; exp_err = 1'b1; end
      if (s_axi_wvalid && mem_ready) begin
        if (n == flip) exp_err = 1'b1;
        n++;
      end
      k++;
    end

    for (int w = 0; w < resp_wait; w++) begin
      @(posedge clk); #1;
      idle_inputs();
      mem_ready = 1'($urandom_range(0, 1));
      chk("resp_busy", 64'(busy), 64'(1));
      if (w == 0 && misuse == 3) begin
        aw_fire = 1'b1; s_axi_awaddr = 32'($urandom); exp_err = 1'b1;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    b_fire = 1'b1;
    chk("resp_busy_b", 64'(busy), 64'(1));
    @(posedge clk); #1;
    b_fire = 1'b0;
    chk("idle_busy", 64'(busy), 64'(0));
    chk("wr_err", 64'(wr_err), 64'(exp_err));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b, size, len, misuse, flip;
    logic [31:0] a0;
    resetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0; mem_ready = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_wr_err", 64'(wr_err), 64'(0));
    chk("reset_burst_done", 64'(burst_done), 64'(0));
    chk("reset_write_ready", 64'(write_ready), 64'(0));
    chk("reset_mem_we", 64'(mem_we), 64'(0));
    resetn = 1'b1;

    do_burst(32'h1000, 3, 3, 1, 1'b0, 32'h0, -1, 0, -1, 2);   // INCR
    do_burst(32'h1018, 3, 3, 2, 1'b0, 32'h0, -1, 0, -1, 3);   // WRAP
    do_burst(32'h1000, 1, 3, 1, 1'b0, 32'he, -1, 0, -1, 1);   // backpressure
    do_burst(32'h1000, 3, 3, 1, 1'b0, 32'h0, 1, 0, -1, 1);    // early wlast
    apply_reset();
    do_burst(32'h1000, 2, 3, 2, 1'b0, 32'h0, -1, 0, -1, 1);   // illegal WRAP len
    do_burst(32'h3000, 3, 2, 1, 1'b0, 32'h0, -1, 1, -1, 1);   // aw in BURST, sticky
    apply_reset();
    do_burst(32'h1000, 7, 3, 1, 1'b0, 32'h0, -1, 0, 1, 1);    // reset mid-burst
    do_burst(32'h2000, 0, 3, 1, 1'b0, 32'h0, -1, 0, -1, 1);   // single beat

    for (int i = 0; i < 40; i++) begin
      b = $urandom_range(0, 9);
      b = (b < 4) ? 1 : (b < 7) ? 2 : (b < 9) ? 0 : 3;
      size = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
      if (b == 2 && $urandom_range(0, 4) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      else len = $urandom_range(0, 15);
      a0 = 32'($urandom_range(0, 32'h3fff));
      if (b == 2) a0 = a0 & ~32'((1 << ((size > 3) ? 3 : size)) - 1);
      misuse = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
      flip = ($urandom_range(0, 11) == 0) ? $urandom_range(0, len) : -1;
      if ($urandom_range(0, 7) == 0) apply_reset();
      do_burst(a0, len, size, b, 1'b1, 32'h0, flip, misuse, -1, $urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) begin
        @(posedge clk); #1;
        b_fire = 1'b1; exp_err = 1'b1;
        @(posedge clk); #1;
        b_fire = 1'b0;
        chk("idle_b_fire_err", 64'(wr_err), 64'(exp_err));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
